mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port 4 KiB data RAM between the instruction-fetch (IF) and load/store (D) ports.
//  Arbitrates round-robin and sequences each access onto the RAM (1-cycle registered read, word-indexed by addr[11:2]).
//  Returns one response pulse per accepted request. Sits between the core pipeline and the RAM instance.
// PARAMETERS
//  ADDR_W   32  request/RAM address width; forwarded unchanged, RAM ignores addr[1:0] and addr[31:12]
//  DATA_W   32  data width; only 32 is supported
//  RR_INIT  0   port favoured after reset when both request (0 = IF, 1 = D)
// PORTS
//  clk            in   1       system clock; all state updates on its rising edge
//  reset_n        in   1       reset, synchronous, active-low
//  if_req_valid   in   1       IF read request
//  if_req_ready   out  1       IF request accepted this cycle
//  if_req_addr    in   ADDR_W  IF byte address
//  if_rsp_valid   out  1       1-cycle pulse, if_rsp_rdata valid
//  if_rsp_rdata   out  DATA_W  fetched word
//  d_req_valid    in   1       D request
//  d_req_ready    out  1       D request accepted this cycle
//  d_req_we       in   1       1 = write, 0 = read
//  d_req_addr     in   ADDR_W  D byte address
//  d_req_wdata    in   DATA_W  write data
//  d_req_wstrb    in   4       byte strobes (used only with MEM_ARB_BYTE_WRITE_EN)
//  d_rsp_valid    out  1       1-cycle pulse: read data valid, or write complete
//  d_rsp_rdata    out  DATA_W  read word; for writes, the word's contents before the write
//  ram_wr_sig     out  1       RAM write enable
//  ram_wr_data    out  DATA_W  RAM write data
//  ram_addr       out  ADDR_W  RAM address
//  ram_rd_data    in   DATA_W  RAM registered read data (valid the cycle after ram_addr)
// BEHAVIOUR
//  Reset (reset_n low at clk edge):
//  - state=IDLE, rr pointer=RR_INIT.
//  - All *_ready, *_rsp_valid and ram_wr_sig = 0; ram_addr, ram_wr_data, rsp_rdata = 0.
//  - Any in-flight transaction is dropped and gets no response.
//  - ram_wr_sig is additionally ANDed with reset_n, so no RAM write occurs in a reset cycle.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE; under the optional feature also IDLE -> ACCESS -> MERGE -> RESP.
//  IDLE grant, combinational:
//  - Only one valid: that port is granted.
//  - Both valid: the port the rr pointer favours is granted; the pointer then flips to the other port.
//  - The granted port's ready = 1; handshake = valid & ready at cycle T.
//  - The request is latched; the next state is ACCESS.
//  - Ready is 0 in every non-IDLE state, so at most one transaction is in flight.
//  ACCESS (T+1):
//  - ram_addr = latched address.
//  - ram_wr_sig = 1 only for a direct D write; ram_wr_data = latched wdata.
//  - The RAM captures the old word at the end of this cycle.
//  RESP:
//  - Owner's rsp_valid = 1 for exactly one cycle; rsp_rdata = ram_rd_data. Then back to IDLE.
//  - Latency: read or direct write, rsp at T+2. A new handshake is possible at T+3.
//  - No response backpressure; requesters must take the pulse.
//  - A requester may hold valid through its response; it is not re-granted before IDLE.
//  Addresses are passed unmodified: misaligned or >4 KiB addresses alias per the RAM decode (not an error).
// CONFIGURATION
//  MEM_ARB_BYTE_WRITE_EN defined:
//  - d_req_wstrb is honoured.
//  - wstrb=4'hF: direct write (as above).
//  - wstrb=4'h0: treated as a read.
//  - Any other wstrb: read-modify-write. ACCESS reads the word. MERGE (T+2) drives ram_wr_sig=1 and ram_wr_data = per-byte mux(wstrb ? wdata : ram_rd_data). RESP at T+3 returns the pre-write word.
//  MEM_ARB_BYTE_WRITE_EN undefined:
//  - wstrb is ignored; every write is a full-word direct write.
//  - The MERGE state and merge logic are not compiled.
// STRUCTURE
//  Package mem_arb_pkg holds:
//  - state encoding localparams (IDLE, ACCESS, MERGE, RESP);
//  - port index constants PORT_IF=0, PORT_D=1;
//  - function merge_bytes(old, new, strb).
//  Sub-module rr_arb2: 2-request round-robin grant plus pointer register (clk, reset_n, req[1:0], take, gnt[1:0]).
//  Everything else (FSM, request latch, RAM drive, response routing) lives in mem_arbiter.
// TESTING
//  Single read: IF reads 0x010 holding 0xDEADBEEF -> if_req_ready at T, if_rsp_valid only at T+2 with 0xDEADBEEF.
//  Direct write: D writes 0xCAFEF00D to 0x020 -> ram_wr_sig=1 only at T+1, d_rsp_valid at T+2; a later read of 0x020 returns 0xCAFEF00D.
//  Contention: IF and D both valid continuously from reset (RR_INIT=0) -> grants IF, D, IF, D with 3-cycle spacing; no port gets two grants in a row.
//  Reset mid-operation: reset_n low in ACCESS of a D write -> no ram_wr_sig, no d_rsp_valid; all outputs 0 the cycle after; grant resumes from IDLE.
//  Byte write (macro on): word 0x11223344, wstrb=4'b0010, wdata 0x0000AA00 -> MERGE writes 0x1122AA44, d_rsp_valid at T+3 with 0x11223344.
//  Macro off: same stimulus -> full write 0x0000AA00, d_rsp_valid at T+2.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the IF/D memory arbiter.
// The optional MEM_ARB_BYTE_WRITE_EN build uses merge_bytes for partial-word writes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam int unsigned PORT_IF = 0;
    localparam int unsigned PORT_D  = 1;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the IF port, D port and RAM-side signals around mem_arbiter.
// slave = arbiter view, master = requesters plus RAM view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_rdata;

    logic              d_req_valid;
    logic              d_req_ready;
    logic              d_req_we;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_wdata;
    logic [3:0]        d_req_wstrb;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_rdata;

    logic              ram_wr_sig;
    logic [DATA_W-1:0] ram_wr_data;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rd_data;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_rdata,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
        output d_req_ready, d_rsp_valid, d_rsp_rdata,
        output ram_wr_sig, ram_wr_data, ram_addr,
        input  ram_rd_data
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata,
        input  ram_wr_sig, ram_wr_data, ram_addr,
        output ram_rd_data
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant; the pointer only moves when both request and a grant is taken.
module rr_arb2 #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);
    logic ptr_q;

    // Grant selection: contention resolved by the pointer, otherwise pass the lone request.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    // Pointer register: flip to the loser after a contended grant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q <= RR_INIT;
        end else if (take && (req == 2'b11)) begin
            ptr_q <= ~ptr_q;
        end else begin
            ptr_q <= ptr_q;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port registered-read RAM between IF and D ports.
// Define MEM_ARB_BYTE_WRITE_EN to honour d_req_wstrb via a read-modify-write MERGE state.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter int unsigned RR_INIT = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);
    state_e            state_q;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ram_wr_q;
    logic              if_rsp_q;
    logic              d_rsp_q;
    logic              rmw_s;

    logic [1:0]        req_s;
    logic [1:0]        gnt_s;
    logic              take_s;
    logic              d_direct_s;
    logic              d_rmw_s;

    assign req_s  = {bus.d_req_valid, bus.if_req_valid};
    assign take_s = (state_q == ST_IDLE) && reset_n && (req_s != 2'b00);

    rr_arb2 #(.RR_INIT(RR_INIT != 0)) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_s),
        .take    (take_s),
        .gnt     (gnt_s)
    );

`ifdef MEM_ARB_BYTE_WRITE_EN
    logic [3:0] wstrb_q;
    logic       rmw_q;

    // Write classification: full strobe writes directly, empty strobe reads, partial strobe merges.
    always_comb begin
        d_direct_s = 1'b0;
        d_rmw_s    = 1'b0;
        if (bus.d_req_we && (bus.d_req_wstrb == 4'hF)) begin
            d_direct_s = 1'b1;
        end else if (bus.d_req_we && (bus.d_req_wstrb != 4'h0)) begin
            d_rmw_s = 1'b1;
        end else begin
            d_direct_s = 1'b0;
        end
    end

    assign rmw_s           = rmw_q;
    assign bus.ram_wr_data = (state_q == ST_MERGE) ? merge_bytes(bus.ram_rd_data, wdata_q, wstrb_q)
                                                   : wdata_q;
`else
    logic unused_wstrb_s;
    assign unused_wstrb_s  = ^bus.d_req_wstrb;
    assign d_direct_s      = bus.d_req_we;
    assign d_rmw_s         = 1'b0;
    assign rmw_s           = 1'b0;
    assign bus.ram_wr_data = wdata_q;
`endif

    assign bus.if_req_ready = take_s & gnt_s[PORT_IF];
    assign bus.d_req_ready  = take_s & gnt_s[PORT_D];
    assign bus.ram_addr     = addr_q;
    // Gate with reset_n so a reset landing mid-write never reaches the RAM.
    assign bus.ram_wr_sig   = ram_wr_q & reset_n;
    assign bus.if_rsp_valid = if_rsp_q;
    assign bus.d_rsp_valid  = d_rsp_q;
    assign bus.if_rsp_rdata = if_rsp_q ? bus.ram_rd_data : '0;
    assign bus.d_rsp_rdata  = d_rsp_q  ? bus.ram_rd_data : '0;

    // Transaction FSM: latch the grant, drive the RAM, pulse the owner's response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ram_wr_q <= 1'b0;
            if_rsp_q <= 1'b0;
            d_rsp_q  <= 1'b0;
`ifdef MEM_ARB_BYTE_WRITE_EN
            rmw_q    <= 1'b0;
            wstrb_q  <= 4'h0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if_rsp_q <= 1'b0;
                    d_rsp_q  <= 1'b0;
                    if (take_s) begin
                        owner_q  <= gnt_s[PORT_D];
                        addr_q   <= gnt_s[PORT_D] ? bus.d_req_addr : bus.if_req_addr;
                        wdata_q  <= gnt_s[PORT_D] ? bus.d_req_wdata : '0;
                        ram_wr_q <= gnt_s[PORT_D] & d_direct_s;
`ifdef MEM_ARB_BYTE_WRITE_EN
                        rmw_q    <= gnt_s[PORT_D] & d_rmw_s;
                        wstrb_q  <= gnt_s[PORT_D] ? bus.d_req_wstrb : 4'h0;
`endif
                        state_q  <= ST_ACCESS;
                    end else begin
                        ram_wr_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (rmw_s) begin
                        ram_wr_q <= 1'b1;
                        state_q  <= ST_MERGE;
                    end else begin
                        ram_wr_q <= 1'b0;
                        if_rsp_q <= (owner_q == 1'b0);
                        d_rsp_q  <= (owner_q == 1'b1);
                        state_q  <= ST_RESP;
                    end
                end
`ifdef MEM_ARB_BYTE_WRITE_EN
                ST_MERGE: begin
                    ram_wr_q <= 1'b0;
                    if_rsp_q <= (owner_q == 1'b0);
                    d_rsp_q  <= (owner_q == 1'b1);
                    state_q  <= ST_RESP;
                end
`endif
                ST_RESP: begin
                    if_rsp_q <= 1'b0;
                    d_rsp_q  <= 1'b0;
                    ram_wr_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    if_rsp_q <= 1'b0;
                    d_rsp_q  <= 1'b0;
                    ram_wr_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    logic unused_d_rmw_s;
    assign unused_d_rmw_s = d_rmw_s;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural registered-read RAM.
// Expectations for the byte-strobe case follow MEM_ARB_BYTE_WRITE_EN.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_INIT(0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // RAM model: read-before-write, word-indexed by addr[11:2]
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        bus.ram_rd_data <= mem[bus.ram_addr[11:2]];
        if (bus.ram_wr_sig) mem[bus.ram_addr[11:2]] <= bus.ram_wr_data;
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_if_q [$];
    logic [31:0] exp_d_q  [$];
    logic [31:0] model_mem [int];
    logic [31:0] exp_v;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload_word(input logic [31:0] addr, input logic [31:0] data);
        step();
        bus.d_req_valid = 1'b1; bus.d_req_we = 1'b1; bus.d_req_addr = addr;
        bus.d_req_wdata = data; bus.d_req_wstrb = 4'hF;
        @(negedge clk);
        checks++;
        if (bus.d_req_ready !== 1'b1) begin
            errors++; $display("FAIL preload_ready addr=%h got=%b want=1", addr, bus.d_req_ready);
        end
        step();
        bus.d_req_valid = 1'b0;
        step();
        step();
        model_mem[int'(addr[11:2])] = data;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.if_req_valid = 1'b1; bus.d_req_valid = 1'b1;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({bus.if_req_ready, bus.d_req_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got=%b want=00", {bus.if_req_ready, bus.d_req_ready});
        end
        checks++;
        if ({bus.if_rsp_valid, bus.d_rsp_valid, bus.ram_wr_sig} !== 3'b000) begin
            errors++; $display("FAIL reset_valids got=%b want=000", {bus.if_rsp_valid, bus.d_rsp_valid, bus.ram_wr_sig});
        end
        checks++;
        if ({bus.ram_addr, bus.ram_wr_data, bus.if_rsp_rdata, bus.d_rsp_rdata} !== 128'h0) begin
            errors++; $display("FAIL reset_data addr=%h wd=%h ifr=%h dr=%h want=0", bus.ram_addr, bus.ram_wr_data, bus.if_rsp_rdata, bus.d_rsp_rdata);
        end
        step();
        bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        preload_word(32'h010, 32'hDEADBEEF);
        step();
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h010;
        exp_if_q.push_back(model_mem[4]);
        @(negedge clk);
        checks++;
        if (bus.if_req_ready !== 1'b1) begin errors++; $display("FAIL read_ready got=%b want=1", bus.if_req_ready); end
        step();
        bus.if_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.if_rsp_valid !== 1'b0) begin errors++; $display("FAIL read_rsp_t1 got=%b want=0", bus.if_rsp_valid); end
        step();
        @(negedge clk);
        checks++;
        if (bus.if_rsp_valid !== 1'b1) begin
            errors++; $display("FAIL read_rsp_t2 got=%b want=1", bus.if_rsp_valid);
        end else begin
            exp_v = exp_if_q.pop_front();
            checks++;
            if (bus.if_rsp_rdata !== exp_v) begin errors++; $display("FAIL read_data got=%h want=%h", bus.if_rsp_rdata, exp_v); end
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.if_rsp_valid !== 1'b0) begin errors++; $display("FAIL read_rsp_t3 got=%b want=0", bus.if_rsp_valid); end
        exp_if_q.delete();
    endtask

    task automatic test_direct_write();
        step();
        bus.d_req_valid = 1'b1; bus.d_req_we = 1'b1; bus.d_req_addr = 32'h020;
        bus.d_req_wdata = 32'hCAFEF00D; bus.d_req_wstrb = 4'hF;
        @(negedge clk);
        checks++;
        if ({bus.d_req_ready, bus.ram_wr_sig} !== 2'b10) begin
            errors++; $display("FAIL wr_t0 ready/wr got=%b want=10", {bus.d_req_ready, bus.ram_wr_sig});
        end
        step();
        bus.d_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.ram_wr_sig, bus.ram_addr, bus.ram_wr_data, bus.d_rsp_valid} !== {1'b1, 32'h020, 32'hCAFEF00D, 1'b0}) begin
            errors++; $display("FAIL wr_t1 wr=%b addr=%h wd=%h rsp=%b want 1/020/CAFEF00D/0", bus.ram_wr_sig, bus.ram_addr, bus.ram_wr_data, bus.d_rsp_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if ({bus.d_rsp_valid, bus.ram_wr_sig} !== 2'b10) begin
            errors++; $display("FAIL wr_t2 rsp/wr got=%b want=10", {bus.d_rsp_valid, bus.ram_wr_sig});
        end
        model_mem[8] = 32'hCAFEF00D;
        step();
        // read back through IF
        step();
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h020;
        exp_if_q.push_back(model_mem[8]);
        step();
        bus.if_req_valid = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (bus.if_rsp_valid !== 1'b1 || exp_if_q.size() == 0) begin
            errors++; $display("FAIL wr_readback_valid got=%b want=1", bus.if_rsp_valid);
        end else begin
            exp_v = exp_if_q.pop_front();
            checks++;
            if (bus.if_rsp_rdata !== exp_v) begin errors++; $display("FAIL wr_readback got=%h want=%h", bus.if_rsp_rdata, exp_v); end
        end
        step();
        // overwrite: response carries the pre-write word
        step();
        bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h020; bus.d_req_wdata = 32'h0BADF00D;
        exp_d_q.push_back(model_mem[8]);
        step();
        bus.d_req_valid = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (bus.d_rsp_valid !== 1'b1 || exp_d_q.size() == 0) begin
            errors++; $display("FAIL wr_old_valid got=%b want=1", bus.d_rsp_valid);
        end else begin
            exp_v = exp_d_q.pop_front();
            checks++;
            if (bus.d_rsp_rdata !== exp_v) begin errors++; $display("FAIL wr_old_data got=%h want=%h", bus.d_rsp_rdata, exp_v); end
        end
        model_mem[8] = 32'h0BADF00D;
        step();
        exp_if_q.delete(); exp_d_q.delete();
    endtask

    task automatic test_contention();
        reset_n = 1'b0;
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h010;
        bus.d_req_valid = 1'b1; bus.d_req_we = 1'b0; bus.d_req_addr = 32'h020; bus.d_req_wstrb = 4'hF;
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.if_req_ready, bus.d_req_ready} !== {(c % 6) == 0, (c % 6) == 3}) begin
                errors++; $display("FAIL rr_grant cycle=%0d got=%b want=%b", c, {bus.if_req_ready, bus.d_req_ready}, {(c % 6) == 0, (c % 6) == 3});
            end
            if (bus.if_req_ready === 1'b1) exp_if_q.push_back(model_mem[4]);
            if (bus.d_req_ready === 1'b1) exp_d_q.push_back(model_mem[8]);
            checks++;
            if ({bus.if_rsp_valid, bus.d_rsp_valid} !== {(c % 6) == 2, (c % 6) == 5}) begin
                errors++; $display("FAIL rr_rsp cycle=%0d got=%b want=%b", c, {bus.if_rsp_valid, bus.d_rsp_valid}, {(c % 6) == 2, (c % 6) == 5});
            end
            if (bus.if_rsp_valid === 1'b1 && exp_if_q.size() != 0) begin
                exp_v = exp_if_q.pop_front();
                checks++;
                if (bus.if_rsp_rdata !== exp_v) begin errors++; $display("FAIL rr_if_data cycle=%0d got=%h want=%h", c, bus.if_rsp_rdata, exp_v); end
            end
            if (bus.d_rsp_valid === 1'b1 && exp_d_q.size() != 0) begin
                exp_v = exp_d_q.pop_front();
                checks++;
                if (bus.d_rsp_rdata !== exp_v) begin errors++; $display("FAIL rr_d_data cycle=%0d got=%h want=%h", c, bus.d_rsp_rdata, exp_v); end
            end
            step();
        end
        bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;
        checks++;
        if (exp_if_q.size() + exp_d_q.size() != 0) begin
            errors++; $display("FAIL rr_outstanding got=%0d want=0", exp_if_q.size() + exp_d_q.size());
        end
        exp_if_q.delete(); exp_d_q.delete();
        step();
    endtask

    task automatic test_reset_mid();
        preload_word(32'h030, 32'h12345678);
        step();
        bus.d_req_valid = 1'b1; bus.d_req_we = 1'b1; bus.d_req_addr = 32'h030;
        bus.d_req_wdata = 32'hFFFFFFFF; bus.d_req_wstrb = 4'hF;
        @(negedge clk);
        checks++;
        if (bus.d_req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b want=1", bus.d_req_ready); end
        step();
        bus.d_req_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ram_wr_sig !== 1'b0) begin errors++; $display("FAIL rstmid_wr got=%b want=0", bus.ram_wr_sig); end
        step();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.d_rsp_valid, bus.if_rsp_valid, bus.ram_wr_sig, bus.ram_addr, bus.ram_wr_data, bus.d_rsp_rdata} !== 99'h0) begin
            errors++; $display("FAIL rstmid_outputs rsp=%b/%b wr=%b addr=%h wd=%h dr=%h want all 0",
                bus.d_rsp_valid, bus.if_rsp_valid, bus.ram_wr_sig, bus.ram_addr, bus.ram_wr_data, bus.d_rsp_rdata);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.d_rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_late_rsp got=%b want=0", bus.d_rsp_valid); end
        step();
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h030;
        exp_if_q.push_back(model_mem[12]);
        @(negedge clk);
        checks++;
        if (bus.if_req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_regrant got=%b want=1", bus.if_req_ready); end
        step();
        bus.if_req_valid = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (bus.if_rsp_valid !== 1'b1 || exp_if_q.size() == 0) begin
            errors++; $display("FAIL rstmid_read_valid got=%b want=1", bus.if_rsp_valid);
        end else begin
            exp_v = exp_if_q.pop_front();
            checks++;
            if (bus.if_rsp_rdata !== exp_v) begin errors++; $display("FAIL rstmid_read got=%h want=%h", bus.if_rsp_rdata, exp_v); end
        end
        step();
        exp_if_q.delete();
    endtask

    task automatic test_byte_write();
        preload_word(32'h040, 32'h11223344);
        step();
        bus.d_req_valid = 1'b1; bus.d_req_we = 1'b1; bus.d_req_addr = 32'h040;
        bus.d_req_wdata = 32'h0000AA00; bus.d_req_wstrb = 4'b0010;
        exp_d_q.push_back(model_mem[16]);
        @(negedge clk);
        checks++;
        if (bus.d_req_ready !== 1'b1) begin errors++; $display("FAIL bw_ready got=%b want=1", bus.d_req_ready); end
        step();
        bus.d_req_valid = 1'b0;
        @(negedge clk);
`ifdef MEM_ARB_BYTE_WRITE_EN
        checks++;
        if (bus.ram_wr_sig !== 1'b0) begin errors++; $display("FAIL bw_t1_wr got=%b want=0", bus.ram_wr_sig); end
        step();
        @(negedge clk);
        checks++;
        if ({bus.ram_wr_sig, bus.ram_wr_data, bus.d_rsp_valid} !== {1'b1, 32'h1122AA44, 1'b0}) begin
            errors++; $display("FAIL bw_merge wr=%b wd=%h rsp=%b want 1/1122AA44/0", bus.ram_wr_sig, bus.ram_wr_data, bus.d_rsp_valid);
        end
        model_mem[16] = 32'h1122AA44;
`else
        checks++;
        if ({bus.ram_wr_sig, bus.ram_wr_data} !== {1'b1, 32'h0000AA00}) begin
            errors++; $display("FAIL bw_full wr=%b wd=%h want 1/0000AA00", bus.ram_wr_sig, bus.ram_wr_data);
        end
        model_mem[16] = 32'h0000AA00;
`endif
        step();
        @(negedge clk);
        checks++;
        if (bus.d_rsp_valid !== 1'b1 || exp_d_q.size() == 0) begin
            errors++; $display("FAIL bw_rsp_valid got=%b want=1", bus.d_rsp_valid);
        end else begin
            exp_v = exp_d_q.pop_front();
            checks++;
            if (bus.d_rsp_rdata !== exp_v) begin errors++; $display("FAIL bw_old_data got=%h want=%h", bus.d_rsp_rdata, exp_v); end
        end
        step();
        step();
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h040;
        exp_if_q.push_back(model_mem[16]);
        step();
        bus.if_req_valid = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (bus.if_rsp_valid !== 1'b1 || exp_if_q.size() == 0) begin
            errors++; $display("FAIL bw_readback_valid got=%b want=1", bus.if_rsp_valid);
        end else begin
            exp_v = exp_if_q.pop_front();
            checks++;
            if (bus.if_rsp_rdata !== exp_v) begin errors++; $display("FAIL bw_readback got=%h want=%h", bus.if_rsp_rdata, exp_v); end
        end
        step();
        exp_if_q.delete(); exp_d_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        bus.if_req_valid = 1'b0; bus.if_req_addr = 32'h0;
        bus.d_req_valid = 1'b0; bus.d_req_we = 1'b0; bus.d_req_addr = 32'h0;
        bus.d_req_wdata = 32'h0; bus.d_req_wstrb = 4'h0;
        test_reset();
        test_single_read();
        test_direct_write();
        test_contention();
        test_reset_mid();
        test_byte_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
